// File: rtl/switch_led_pkg.sv
// Shared types and helpers for the switch-to-LED controller.
// The PWM build is selected with the SWITCH_LED_PWM_EN macro in the top module.
package switch_led_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_INVERT = 2'b11
  } mode_e;

  // Counter width able to hold 0..cycles.
  function automatic int db_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_led_ctrl_sw_debounce.sv
// One switch channel: 2-flop synchroniser followed by a consecutive-stable-cycles
// debouncer that only accepts a change once it has held for DEBOUNCE_CYCLES cycles.
module sw_debounce
  import switch_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic srst,
  input  logic sw,
  output logic sw_db
);

  localparam int CW = db_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          db_reg;
  logic          db_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // Any cycle where the synced bit agrees with the stable state restarts the count.
  always_comb begin
    cnt_next = '0;
    db_next  = db_reg;
    if (sync2_reg != db_reg) begin
      if (cnt_reg == CNT_LAST) begin
        db_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      db_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= sw;
      sync2_reg <= sync1_reg;
      db_reg    <= db_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign sw_db = db_reg;

endmodule

// File: rtl/switch_led_ctrl.sv
// Debounced slide switches mapped to LEDs via a run-time mode (direct/toggle/blink/invert).
// Define SWITCH_LED_PWM_EN to add the DUTY port and PWM brightness gating.
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int N                 = 16,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int BLINK_HALF_PERIOD = 25000000,
  parameter int PWM_BITS          = 4
) (
  input  logic                CLK100MHZ,
  input  logic                RST,
  input  logic [N-1:0]        SW,
  input  logic [1:0]          MODE,
`ifdef SWITCH_LED_PWM_EN
  input  logic [PWM_BITS-1:0] DUTY,
`endif
  output logic [N-1:0]        LED,
  output logic [N-1:0]        SW_DB
);

  localparam int BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

  logic [N-1:0]  db;
  logic [N-1:0]  db_prev_reg;
  logic [N-1:0]  tog_reg;
  logic [N-1:0]  tog_next;
  logic [N-1:0]  mode_out;
  logic [N-1:0]  led_reg;
  logic [N-1:0]  led_next;
  logic [1:0]    mode_s1_reg;
  mode_e         mode_s2_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic [BW-1:0] blink_cnt_next;
  logic          phase_reg;
  logic          phase_next;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (CLK100MHZ),
        .srst (RST),
        .sw   (SW[gi]),
        .sw_db(db[gi])
      );
    end
  endgenerate

  // Latches flip on debounced rising edges regardless of the displayed mode.
  assign tog_next = tog_reg ^ (db & ~db_prev_reg);

  always_comb begin
    blink_cnt_next = blink_cnt_reg + 1'b1;
    phase_next     = phase_reg;
    if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_next = '0;
      phase_next     = ~phase_reg;
    end
  end

  always_comb begin
    mode_out = db;
    unique case (mode_s2_reg)
      MODE_DIRECT: mode_out = db;
      MODE_TOGGLE: mode_out = tog_reg;
      MODE_BLINK:  mode_out = db & {N{phase_reg}};
      MODE_INVERT: mode_out = ~db;
      default:     mode_out = db;
    endcase
  end

`ifdef SWITCH_LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_reg;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  assign led_next = mode_out & {N{pwm_cnt_reg < DUTY}};
`else
  // PWM_BITS is only consumed by the PWM build; this keeps the parameter referenced.
  if (PWM_BITS < 1) begin : g_pwm_bits_unused
  end

  assign led_next = mode_out;
`endif

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      mode_s1_reg   <= 2'b00;
      mode_s2_reg   <= MODE_DIRECT;
      db_prev_reg   <= '0;
      tog_reg       <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      led_reg       <= '0;
    end else begin
      mode_s1_reg   <= MODE;
      mode_s2_reg   <= mode_e'(mode_s1_reg);
      db_prev_reg   <= db;
      tog_reg       <= tog_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      led_reg       <= led_next;
    end
  end

  assign LED   = led_reg;
  assign SW_DB = db;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed self-checking bench for switch_led_ctrl (N=4, short debounce/blink periods).
// PWM checks are compiled in when SWITCH_LED_PWM_EN is defined.
module tb_switch_led_ctrl;

  localparam int N  = 4;
  localparam int DC = 4;
  localparam int BH = 3;
  localparam int PB = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic [N-1:0] sw_db;
`ifdef SWITCH_LED_PWM_EN
  logic [PB-1:0] duty;
`endif

  always #5 clk = ~clk;

  switch_led_ctrl #(
    .N                (N),
    .DEBOUNCE_CYCLES  (DC),
    .BLINK_HALF_PERIOD(BH),
    .PWM_BITS         (PB)
  ) dut (
    .CLK100MHZ(clk),
    .RST      (rst),
    .SW       (sw),
    .MODE     (mode),
`ifdef SWITCH_LED_PWM_EN
    .DUTY     (duty),
`endif
    .LED      (led),
    .SW_DB    (sw_db)
  );

  typedef struct {
    string        tag;
    bit           is_db;
    logic [N-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_led(input string tag, input logic [N-1:0] v);
    exp_t e;
    e.tag = tag; e.is_db = 1'b0; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_db(input string tag, input logic [N-1:0] v);
    exp_t e;
    e.tag = tag; e.is_db = 1'b1; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [N-1:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = e.is_db ? sw_db : led;
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
      end
      $display("check %s observed=%b expected=%b", e.tag, obs, e.val);
    end
  endtask

  task automatic do_reset(input logic [N-1:0] sw_v, input logic [1:0] mode_v);
    rst  = 1'b1;
    sw   = sw_v;
    mode = mode_v;
    step(2);
    rst  = 1'b0;
  endtask

`ifdef SWITCH_LED_PWM_EN
  task automatic pwm_count(input string tag, input int want);
    int hi;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (led === 4'hF) hi++;
    end
    checks++;
    assert (hi == want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, hi, want);
    end
    $display("check %s high_cycles=%0d expected=%0d", tag, hi, want);
  endtask
`endif

  initial begin
    rst  = 1'b1;
    sw   = '0;
    mode = 2'b00;
`ifdef SWITCH_LED_PWM_EN
    duty = '1;
`endif

    // Reset with all switches high: outputs held at zero, then 2+DC edge latency.
    rst = 1'b1; sw = 4'hF; mode = 2'b00;
    step(2);
    exp_led("rst_led", 4'h0);
    exp_db("rst_db", 4'h0);
    check_out();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      exp_db($sformatf("rst_rel_db_k%0d", k), (k >= 6) ? 4'hF : 4'h0);
      exp_led($sformatf("rst_rel_led_k%0d", k), (k >= 7) ? 4'hF : 4'h0);
      step(1);
      check_out();
    end

    // 3-cycle glitch is rejected; a held change is accepted.
    do_reset(4'h0, 2'b00);
    step(3);
    sw = 4'b0001;
    step(3);
    sw = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      exp_db($sformatf("glitch_db_k%0d", k), 4'h0);
      exp_led($sformatf("glitch_led_k%0d", k), 4'h0);
      step(1);
      check_out();
    end
    sw = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      exp_db($sformatf("stable_db_k%0d", k), (k >= 6) ? 4'b0001 : 4'b0000);
      exp_led($sformatf("stable_led_k%0d", k), (k >= 7) ? 4'b0001 : 4'b0000);
      step(1);
      check_out();
    end

    // Toggle mode: presses flip LED[1], releases do not.
    do_reset(4'h0, 2'b01);
    step(3);
    exp_led("tog_idle", 4'h0);
    check_out();
    sw = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      exp_led($sformatf("tog_press1_k%0d", k), (k >= 8) ? 4'b0010 : 4'b0000);
      step(1);
      check_out();
    end
    sw = 4'b0000;
    step(10);
    exp_led("tog_release1", 4'b0010);
    check_out();
    sw = 4'b0010;
    step(7);
    exp_led("tog_press2_before", 4'b0010);
    check_out();
    step(1);
    exp_led("tog_press2_after", 4'b0000);
    check_out();
    sw = 4'b0000;
    step(10);
    exp_led("tog_release2", 4'b0000);
    check_out();

    // Blink: phase off for the first BH edges after reset, then alternates every BH edges.
    do_reset(4'b0101, 2'b10);
    for (int k = 1; k <= 24; k++) begin
      exp_led($sformatf("blink_k%0d", k),
              (k >= 7 && ((k - 1) / BH) % 2 == 1) ? 4'b0101 : 4'b0000);
      step(1);
      check_out();
    end

    // Mode change to INVERT lands on the third edge.
    do_reset(4'b0011, 2'b00);
    step(10);
    exp_led("inv_pre_led", 4'b0011);
    exp_db("inv_pre_db", 4'b0011);
    check_out();
    mode = 2'b11;
    step(2);
    exp_led("inv_edge2", 4'b0011);
    check_out();
    step(1);
    exp_led("inv_edge3", 4'b1100);
    check_out();

    // Reset in the middle of a debounce throws the partial count away.
    sw = 4'hF;
    step(4);
    rst = 1'b1;
    step(1);
    exp_led("middb_rst_led", 4'h0);
    exp_db("middb_rst_db", 4'h0);
    check_out();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      exp_db($sformatf("middb_db_k%0d", k), (k >= 6) ? 4'hF : 4'h0);
      exp_led($sformatf("middb_led_k%0d", k), (k >= 3 && k <= 6) ? 4'hF : 4'h0);
      step(1);
      check_out();
    end

`ifdef SWITCH_LED_PWM_EN
    // PWM gating over two full 4-cycle periods.
    duty = 2'd0;
    do_reset(4'hF, 2'b00);
    step(10);
    for (int k = 1; k <= 8; k++) begin
      exp_led($sformatf("pwm_d0_k%0d", k), 4'h0);
      step(1);
      check_out();
    end
    duty = 2'd2;
    step(1);
    pwm_count("pwm_d2_high", 4);
    duty = 2'd3;
    step(1);
    pwm_count("pwm_d3_high", 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
